// File: rtl/block_mac_ctrl.sv
// saturate: arithmetic shift right by FRAC_WDITH, then clamp to BIT_WIDTH signed range.
// Latency: combinational. Backpressure: none (pure function).
module saturate #(
    parameter int BIT_WIDTH  = 16,
    parameter int FRAC_WDITH = 8
) (
    input  logic signed [2*BIT_WIDTH-1:0] acc_i,
    output logic signed [BIT_WIDTH-1:0]   sat_o
);
    localparam logic signed [2*BIT_WIDTH-1:0] MAXV = {{(BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [2*BIT_WIDTH-1:0] MINV = {{(BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

    logic signed [2*BIT_WIDTH-1:0] shifted;
    assign shifted = acc_i >>> FRAC_WDITH;

    always_comb begin
        sat_o = shifted[BIT_WIDTH-1:0];
        if (shifted > MAXV) begin
            sat_o = MAXV[BIT_WIDTH-1:0];
        end else if (shifted < MINV) begin
            sat_o = MINV[BIT_WIDTH-1:0];
        end
    end
endmodule

// block_mac_ctrl: VEC_LEN-beat signed dot product with clamping accumulator and saturated result.
// Latency: result valid 1 cycle after the last operand beat; done pulses 1 cycle after output handshake.
// Backpressure: in_ready/out_valid are registered from state; output held until out_ready.
module block_mac_ctrl #(
    parameter int BIT_WIDTH  = 16,
    parameter int FRAC_WDITH = 8,
    parameter int VEC_LEN    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BIT_WIDTH-1:0] a_in,
    input  logic signed [BIT_WIDTH-1:0] b_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic        [BIT_WIDTH-1:0] out_data,
    output logic                        busy,
    output logic                        done
);
    localparam int AW = 2 * BIT_WIDTH;
    localparam int CW = $clog2(VEC_LEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);
    localparam logic signed [AW-1:0] AMAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] AMIN = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                      state_q;
    logic signed [AW-1:0]        acc_q;
    logic        [CW-1:0]        count_q;
    logic        [BIT_WIDTH-1:0] out_data_q;
    logic                        in_ready_q;
    logic                        out_valid_q;
    logic                        busy_q;
    logic                        done_q;

    logic signed [AW-1:0]        prod;
    logic        [AW:0]          sum;
    logic signed [AW-1:0]        acc_d;
    logic signed [BIT_WIDTH-1:0] sat_d;
    logic                        beat;

    assign prod = a_in * b_in;
    assign sum  = {acc_q[AW-1], acc_q} + {prod[AW-1], prod};
    assign beat = in_valid & in_ready_q;

    // Top two bits of the extended sum disagree only on overflow; their MSB gives the direction.
    always_comb begin
        acc_d = sum[AW-1:0];
        if (sum[AW] != sum[AW-1]) begin
            acc_d = sum[AW] ? AMIN : AMAX;
        end
    end

    saturate #(
        .BIT_WIDTH (BIT_WIDTH),
        .FRAC_WDITH(FRAC_WDITH)
    ) u_saturate (
        .acc_i(acc_d),
        .sat_o(sat_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q      <= '0;
                        count_q    <= '0;
                        state_q    <= ACCUM;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_q   <= acc_d;
                        count_q <= count_q + CW'(1);
                        if (count_q == LAST) begin
                            out_data_q  <= sat_d;
                            state_q     <= OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_block_mac_ctrl.sv
// Directed bench for block_mac_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_block_mac_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [15:0] a_in, b_in;
    logic        in_ready, out_valid, busy, done;
    logic [15:0] out_data;

    int tests = 0;
    int fails = 0;

    block_mac_ctrl #(.BIT_WIDTH(16), .FRAC_WDITH(8), .VEC_LEN(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [15:0] basic_a [4] = '{16'h0100, 16'h0200, 16'h0080, 16'hFF00};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            fails++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if ({in_ready, out_valid, busy, done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 0000", {in_ready, out_valid, busy, done});
        end
        tests++;
        if (out_data !== 16'h0000) begin
            fails++;
            $display("FAIL reset_data: got %h required 0000", out_data);
        end
    endtask

    task automatic test_basic();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle_busy: got %b required 0", busy);
        end
        do_start();
        tests++;
        if ({busy, in_ready} !== 2'b11) begin
            fails++;
            $display("FAIL basic_accum: busy,in_ready=%b required 11", {busy, in_ready});
        end
        for (int i = 0; i < 4; i++) send(basic_a[i], 16'h0100);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h0280 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_out: vld=%b dat=%h rdy=%b required 1 0280 0", out_valid, out_data, in_ready);
        end
        tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_pre_done: done=%b busy=%b required 0 1", done, busy);
        end
        handshake();
        tests++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: done=%b vld=%b busy=%b required 1 0 0", done, out_valid, busy);
        end
        tick();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_saturation();
        do_start();
        for (int i = 0; i < 4; i++) send(16'h7F00, 16'h0200);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h7FFF) begin
            fails++;
            $display("FAIL sat_pos: vld=%b dat=%h required 1 7fff", out_valid, out_data);
        end
        handshake();
        do_start();
        for (int i = 0; i < 4; i++) send(16'h7F00, 16'h8100);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h8000) begin
            fails++;
            $display("FAIL sat_neg: vld=%b dat=%h required 1 8000", out_valid, out_data);
        end
        handshake();
    endtask

    task automatic test_acc_clamp();
        do_start();
        for (int i = 0; i < 4; i++) send(16'h7F00, 16'h7F00);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h7FFF) begin
            fails++;
            $display("FAIL acc_clamp: vld=%b dat=%h required 1 7fff", out_valid, out_data);
        end
        handshake();
    endtask

    task automatic test_stalls();
        logic [6:0] pat = 7'b1011001;
        int k = 0;
        do_start();
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            a_in = basic_a[k % 4];
            b_in = 16'h0100;
            tick();
            if (pat[i]) k++;
        end
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h0280) begin
            fails++;
            $display("FAIL stall_out: vld=%b dat=%h required 1 0280", out_valid, out_data);
        end
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_data !== 16'h0280 || in_ready !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL backpressure_hold: vld=%b dat=%h rdy=%b busy=%b required 1 0280 0 1",
                         out_valid, out_data, in_ready, busy);
            end
        end
        start = 1'b0;
        handshake();
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL stall_done: done=%b required 1", done);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_start_ignored: busy=%b rdy=%b required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_reset_midop();
        do_start();
        send(16'h7F00, 16'h7F00);
        send(16'h1234, 16'h4321);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({in_ready, out_valid, busy, done} !== 4'b0000 || out_data !== 16'h0000) begin
            fails++;
            $display("FAIL midop_reset: ctrl=%b dat=%h required 0000 0000",
                     {in_ready, out_valid, busy, done}, out_data);
        end
        do_start();
        for (int i = 0; i < 4; i++) send(basic_a[i], 16'h0100);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h0280) begin
            fails++;
            $display("FAIL midop_rerun: vld=%b dat=%h required 1 0280", out_valid, out_data);
        end
        handshake();
        tick();
    endtask

    task automatic test_back_to_back();
        do_start();
        for (int i = 0; i < 4; i++) send(16'h0100, 16'h0100);
        tests++;
        if (out_data !== 16'h0400) begin
            fails++;
            $display("FAIL b2b_first: dat=%h required 0400", out_data);
        end
        handshake();
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_done: done=%b required 1", done);
        end
        do_start();
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: rdy=%b busy=%b required 1 1", in_ready, busy);
        end
        for (int i = 0; i < 4; i++) send(basic_a[i], 16'h0100);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h0280) begin
            fails++;
            $display("FAIL b2b_second: vld=%b dat=%h required 1 0280", out_valid, out_data);
        end
        handshake();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_saturation();
        test_acc_clamp();
        test_stalls();
        test_reset_midop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
